// File: rtl/blinkled_mem_pkg.sv
// rtl/blinkled_mem_pkg.sv - shared types, limits and byte-merge helper for the dual-port RAM
package blinkled_mem_pkg;

   localparam int RD_LAT_MAX = 2;
   localparam int ADDR_W_MAX = 32;
   localparam int DATA_W_MAX = 256;
   localparam int BE_W_MAX   = DATA_W_MAX / 8;

   typedef struct packed {
      logic                  valid;
      logic                  oor;
      logic [ADDR_W_MAX-1:0] addr;
   } rd_pipe_t;

   // Lanes with be=1 take new_data, the rest keep old_data.
   function automatic logic [DATA_W_MAX-1:0] be_merge(
      input logic [DATA_W_MAX-1:0] old_data,
      input logic [DATA_W_MAX-1:0] new_data,
      input logic [BE_W_MAX-1:0]   be
   );
      logic [DATA_W_MAX-1:0] merged;
      merged = old_data;
      for (int b = 0; b < BE_W_MAX; b++) begin
         if (be[b]) merged[b*8 +: 8] = new_data[b*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/blinkled_mem_rd_pipe.sv
// rtl/blinkled_mem_rd_pipe.sv - per-port read valid/out-of-range pipeline and output hold register
module blinkled_mem_rd_pipe
   import blinkled_mem_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  en,
   input  rd_pipe_t              req,
   input  logic [DATA_W-1:0]     ram_rdata,
   input  logic                  fwd_valid,
   input  logic [ADDR_W_MAX-1:0] fwd_addr,
   input  logic [DATA_W-1:0]     fwd_data,
   input  logic [DATA_W/8-1:0]   fwd_be,
   output logic [DATA_W-1:0]     readdata,
   output logic                  readdatavalid
);

   localparam int LAT = (READ_LATENCY >= RD_LAT_MAX) ? RD_LAT_MAX : 1;

   rd_pipe_t          st0_q;
   logic [DATA_W-1:0] hold_q;
   logic [DATA_W-1:0] fresh0;
   logic [DATA_W-1:0] last_data;
   logic              last_valid;
   logic              fwd_hit;

   // The forwarded write was accepted on the same edge as the read now in stage 0.
   assign fwd_hit = fwd_valid & st0_q.valid & (st0_q.addr == fwd_addr);

   always_comb begin
      fresh0 = ram_rdata;
      if (fwd_hit) begin
         fresh0 = DATA_W'(be_merge(DATA_W_MAX'(ram_rdata), DATA_W_MAX'(fwd_data),
                                   BE_W_MAX'(fwd_be)));
      end
      if (st0_q.oor) fresh0 = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st0_q  <= '0;
         hold_q <= '0;
      end else if (en) begin
         st0_q  <= req;
         hold_q <= readdata;
      end
   end

   if (LAT == 2) begin : g_lat2
      logic              st1_valid_q;
      logic [DATA_W-1:0] data1_q;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            st1_valid_q <= 1'b0;
            data1_q     <= '0;
         end else if (en) begin
            st1_valid_q <= st0_q.valid;
            if (st0_q.valid) data1_q <= fresh0;
         end
      end

      assign last_valid = st1_valid_q;
      assign last_data  = data1_q;
   end else begin : g_lat1
      assign last_valid = st0_q.valid;
      assign last_data  = fresh0;
   end

   // A frozen cycle masks the strobe; the stage holds so it emerges once enabled.
   assign readdatavalid = last_valid & en;
   assign readdata      = readdatavalid ? last_data : hold_q;

endmodule

// File: rtl/blinkled_dual_port_memory.sv
// rtl/blinkled_dual_port_memory.sv - true dual-port Avalon-MM RAM; option BLINKLED_MEM_RDW_BYPASS_EN
module blinkled_dual_port_memory
   import blinkled_mem_pkg::*;
#(
   parameter int    DATA_W       = 32,
   parameter int    ADDR_W       = 16,
   parameter int    DEPTH        = 50000,
   parameter int    READ_LATENCY = 1,
   parameter string INIT_FILE    = "blinkled_program_memory.hex"
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clken,
   input  logic                reset_req,
   input  logic [ADDR_W-1:0]   s1_address,
   input  logic                s1_chipselect,
   input  logic                s1_read,
   input  logic                s1_write,
   input  logic [DATA_W/8-1:0] s1_byteenable,
   input  logic [DATA_W-1:0]   s1_writedata,
   output logic [DATA_W-1:0]   s1_readdata,
   output logic                s1_readdatavalid,
   output logic                s1_waitrequest,
   input  logic [ADDR_W-1:0]   s2_address,
   input  logic                s2_chipselect,
   input  logic                s2_read,
   input  logic                s2_write,
   input  logic [DATA_W/8-1:0] s2_byteenable,
   input  logic [DATA_W-1:0]   s2_writedata,
   output logic [DATA_W-1:0]   s2_readdata,
   output logic                s2_readdatavalid,
   output logic                s2_waitrequest
);

   localparam int              BE_W      = DATA_W / 8;
   localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ram_q1, ram_q2;

   logic en, collision;
   logic s1_oor, s2_oor;
   logic s1_wr_acc, s1_rd_acc, s2_wr_acc, s2_rd_acc;
   logic [IDX_W-1:0] s1_idx, s2_idx;
   rd_pipe_t s1_req, s2_req;

   assign en = clken & ~reset_req;

   // Only a same-address double write stalls, and s2 is the one that retries.
   assign collision = s1_chipselect & s1_write & s2_chipselect & s2_write &
                      (s1_address == s2_address);

   assign s1_waitrequest = ~en;
   assign s2_waitrequest = ~en | collision;

   assign s1_wr_acc = en & s1_chipselect & s1_write;
   assign s1_rd_acc = en & s1_chipselect & s1_read & ~s1_write;
   assign s2_wr_acc = en & s2_chipselect & s2_write & ~collision;
   assign s2_rd_acc = en & s2_chipselect & s2_read & ~s2_write;

   assign s1_oor = {1'b0, s1_address} >= DEPTH_EXT;
   assign s2_oor = {1'b0, s2_address} >= DEPTH_EXT;
   assign s1_idx = s1_address[IDX_W-1:0];
   assign s2_idx = s2_address[IDX_W-1:0];

   assign s1_req.valid = s1_rd_acc;
   assign s1_req.oor   = s1_oor;
   assign s1_req.addr  = ADDR_W_MAX'(s1_address);
   assign s2_req.valid = s2_rd_acc;
   assign s2_req.oor   = s2_oor;
   assign s2_req.addr  = ADDR_W_MAX'(s2_address);

   // Registered reads see the array before this edge's writes: opposite-port reads get OLD data.
   always_ff @(posedge clk) begin
      if (s1_wr_acc && !s1_oor) begin
         for (int b = 0; b < BE_W; b++) begin
            if (s1_byteenable[b]) mem[s1_idx][b*8 +: 8] <= s1_writedata[b*8 +: 8];
         end
      end
      if (s2_wr_acc && !s2_oor) begin
         for (int b = 0; b < BE_W; b++) begin
            if (s2_byteenable[b]) mem[s2_idx][b*8 +: 8] <= s2_writedata[b*8 +: 8];
         end
      end
      if (s1_rd_acc) ram_q1 <= mem[s1_idx];
      if (s2_rd_acc) ram_q2 <= mem[s2_idx];
   end

   logic                  fwd_valid_q;
   logic [ADDR_W_MAX-1:0] fwd_addr_q;
   logic [DATA_W-1:0]     fwd_data_q;
   logic [BE_W-1:0]       fwd_be_q;

`ifdef BLINKLED_MEM_RDW_BYPASS_EN
   // Capture the s1 write alongside the s2 read so stage 0 can merge the new bytes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fwd_valid_q <= 1'b0;
         fwd_addr_q  <= '0;
         fwd_data_q  <= '0;
         fwd_be_q    <= '0;
      end else if (en) begin
         fwd_valid_q <= s1_wr_acc & ~s1_oor;
         fwd_addr_q  <= ADDR_W_MAX'(s1_address);
         fwd_data_q  <= s1_writedata;
         fwd_be_q    <= s1_byteenable;
      end
   end
`else
   assign fwd_valid_q = 1'b0;
   assign fwd_addr_q  = '0;
   assign fwd_data_q  = '0;
   assign fwd_be_q    = '0;
`endif

   blinkled_mem_rd_pipe #(
      .DATA_W       (DATA_W),
      .READ_LATENCY (READ_LATENCY)
   ) u_rd_pipe_s1 (
      .clk           (clk),
      .reset_n       (reset_n),
      .en            (en),
      .req           (s1_req),
      .ram_rdata     (ram_q1),
      .fwd_valid     (1'b0),
      .fwd_addr      ('0),
      .fwd_data      ('0),
      .fwd_be        ('0),
      .readdata      (s1_readdata),
      .readdatavalid (s1_readdatavalid)
   );

   blinkled_mem_rd_pipe #(
      .DATA_W       (DATA_W),
      .READ_LATENCY (READ_LATENCY)
   ) u_rd_pipe_s2 (
      .clk           (clk),
      .reset_n       (reset_n),
      .en            (en),
      .req           (s2_req),
      .ram_rdata     (ram_q2),
      .fwd_valid     (fwd_valid_q),
      .fwd_addr      (fwd_addr_q),
      .fwd_data      (fwd_data_q),
      .fwd_be        (fwd_be_q),
      .readdata      (s2_readdata),
      .readdatavalid (s2_readdatavalid)
   );

endmodule

// File: tb/tb_blinkled_dual_port_memory.sv
// tb/tb_blinkled_dual_port_memory.sv - directed self-checking bench for blinkled_dual_port_memory
module tb_blinkled_dual_port_memory;

   localparam int AW  = 8;
   localparam int DEP = 64;
   localparam int RL  = 2;

   logic clk = 1'b0;
   logic reset_n, clken, reset_req;
   logic [AW-1:0] s1_address, s2_address;
   logic          s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
   logic [3:0]    s1_byteenable, s2_byteenable;
   logic [31:0]   s1_writedata, s2_writedata, s1_readdata, s2_readdata;
   logic          s1_readdatavalid, s1_waitrequest, s2_readdatavalid, s2_waitrequest;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   blinkled_dual_port_memory #(
      .DATA_W(32), .ADDR_W(AW), .DEPTH(DEP), .READ_LATENCY(RL), .INIT_FILE("")
   ) dut (
      .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
      .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
      .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
      .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
      .s1_waitrequest(s1_waitrequest),
      .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
      .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
      .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
      .s2_waitrequest(s2_waitrequest)
   );

   function automatic logic [31:0] pat(input int i);
      return 32'h5A000000 + 32'(i) * 32'h00010203;
   endfunction

   task automatic drive(input int port, input logic rd, input logic wr, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      if (port == 1) begin
         s1_chipselect = rd | wr; s1_read = rd; s1_write = wr;
         s1_address = a; s1_writedata = d; s1_byteenable = be;
      end else begin
         s2_chipselect = rd | wr; s2_read = rd; s2_write = wr;
         s2_address = a; s2_writedata = d; s2_byteenable = be;
      end
   endtask

   task automatic do_write(input int port, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] be);
      @(posedge clk); #1;
      drive(port, 1'b0, 1'b1, a, d, be);
      @(posedge clk); #1;
      drive(port, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
   endtask

   // Called at posedge+1 just after the accepting edge; lat counts cycles from acceptance.
   task automatic wait_valid(input int port, output logic [31:0] d, output int lat);
      d = 'x;
      lat = -1;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if ((port == 1) ? s1_readdatavalid : s2_readdatavalid) begin
            d = (port == 1) ? s1_readdata : s2_readdata;
            lat = n;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic do_read(input int port, input logic [7:0] a, output logic [31:0] d,
                          output int lat);
      @(posedge clk); #1;
      drive(port, 1'b1, 1'b0, a, 32'd0, 4'd0);
      @(posedge clk); #1;
      drive(port, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
      wait_valid(port, d, lat);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      int lat;
      bit seen;
      reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
      drive(1, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
      drive(2, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
      repeat (3) @(negedge clk);
      checks++;
      if ({s1_readdata, s2_readdata} !== 64'd0) begin
         errors++; $display("FAIL reset_readdata got %h/%h exp 0", s1_readdata, s2_readdata);
      end
      checks++;
      if ({s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got %b%b%b%b exp 0000", s1_readdatavalid, s2_readdatavalid,
                  s1_waitrequest, s2_waitrequest);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      do_write(1, 8'd3, 32'hDEADBEEF, 4'hF);
      @(posedge clk); #1;
      drive(1, 1'b1, 1'b0, 8'd3, 32'd0, 4'd0);
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
      reset_n = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (s1_readdatavalid) seen = 1'b1;
         @(posedge clk); #1;
         if (n == 1) reset_n = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL reset_flush valid seen=%0d exp 0", seen);
      end
      checks++;
      if (s1_readdata !== 32'd0) begin
         errors++; $display("FAIL reset_flush_data got %h exp 0", s1_readdata);
      end
      do_read(1, 8'd3, d, lat);
      checks++;
      if (d !== 32'hDEADBEEF || lat != RL) begin
         errors++; $display("FAIL reset_ram_kept got %h lat %0d exp deadbeef lat %0d", d, lat, RL);
      end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] d;
      int lat;
      do_write(1, 8'd5, 32'hAABBCCDD, 4'b1111);
      do_write(1, 8'd5, 32'h11223344, 4'b0101);
      do_read(2, 8'd5, d, lat);
      checks++;
      if (d !== 32'hAA22CC44) begin
         errors++; $display("FAIL byte_lanes got %h exp aa22cc44", d);
      end
      checks++;
      if (lat != RL) begin
         errors++; $display("FAIL read_latency got %0d exp %0d", lat, RL);
      end
   endtask

   task automatic test_collision();
      logic [31:0] d;
      int lat;
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b1, 8'd9, 32'h1, 4'hF);
      drive(2, 1'b0, 1'b1, 8'd9, 32'h2, 4'hF);
      @(negedge clk);
      checks++;
      if (s2_waitrequest !== 1'b1 || s1_waitrequest !== 1'b0) begin
         errors++;
         $display("FAIL collision_wait got s1 %b s2 %b exp s1 0 s2 1", s1_waitrequest, s2_waitrequest);
      end
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
      @(negedge clk);
      checks++;
      if (s2_waitrequest !== 1'b0) begin
         errors++; $display("FAIL collision_retry got %b exp 0", s2_waitrequest);
      end
      @(posedge clk); #1;
      drive(2, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
      do_read(1, 8'd9, d, lat);
      checks++;
      if (d !== 32'h2) begin
         errors++; $display("FAIL collision_final got %h exp 00000002", d);
      end
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b1, 8'd10, 32'hA0A0A0A0, 4'hF);
      drive(2, 1'b0, 1'b1, 8'd11, 32'hB1B1B1B1, 4'hF);
      @(negedge clk);
      checks++;
      if (s2_waitrequest !== 1'b0) begin
         errors++; $display("FAIL no_collision_wait got %b exp 0", s2_waitrequest);
      end
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
      drive(2, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
      do_read(2, 8'd10, d, lat);
      checks++;
      if (d !== 32'hA0A0A0A0) begin
         errors++; $display("FAIL dual_write_s1 got %h exp a0a0a0a0", d);
      end
      do_read(1, 8'd11, d, lat);
      checks++;
      if (d !== 32'hB1B1B1B1) begin
         errors++; $display("FAIL dual_write_s2 got %h exp b1b1b1b1", d);
      end
   endtask

   task automatic test_streaming();
      int got = 0;
      int first = -1;
      int last = -1;
      bit consec = 1'b1;
      bit wait_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         drive(1, 1'b0, 1'b1, 8'(2 * i), pat(2 * i), 4'hF);
         drive(2, 1'b0, 1'b1, 8'(2 * i + 1), pat(2 * i + 1), 4'hF);
      end
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
      drive(2, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
      for (int c = 0; c < 22; c++) begin
         if (c < 16) drive(1, 1'b1, 1'b0, 8'(c), 32'd0, 4'd0);
         else drive(1, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
         @(negedge clk);
         if (c < 16 && s1_waitrequest) wait_seen = 1'b1;
         if (s1_readdatavalid) begin
            checks++;
            if (s1_readdata !== pat(got)) begin
               errors++; $display("FAIL stream_data idx %0d got %h exp %h", got, s1_readdata, pat(got));
            end
            if (got == 0) first = c;
            else if (c != last + 1) consec = 1'b0;
            last = c;
            got++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (got != 16 || first != RL || !consec) begin
         errors++;
         $display("FAIL stream_timing count %0d first %0d consec %0d exp 16 %0d 1", got, first, consec, RL);
      end
      checks++;
      if (wait_seen) begin
         errors++; $display("FAIL stream_waitrequest got 1 exp 0");
      end
   endtask

   task automatic test_out_of_range();
      logic [31:0] d;
      int lat;
      do_write(1, 8'(DEP), 32'hFFFFFFFF, 4'hF);
      do_read(1, 8'd0, d, lat);
      checks++;
      if (d !== pat(0)) begin
         errors++; $display("FAIL oor_write_dropped got %h exp %h", d, pat(0));
      end
      do_read(2, 8'(DEP + 3), d, lat);
      checks++;
      if (d !== 32'd0 || lat != RL) begin
         errors++; $display("FAIL oor_read got %h lat %0d exp 0 lat %0d", d, lat, RL);
      end
      do_read(1, 8'd255, d, lat);
      checks++;
      if (d !== 32'd0 || lat != RL) begin
         errors++; $display("FAIL oor_read_top got %h lat %0d exp 0 lat %0d", d, lat, RL);
      end
   endtask

   task automatic test_freeze();
      int exp_cyc[8] = '{2, 6, 7, 8, 9, 10, 11, 12};
      int ptr = 0;
      int got = 0;
      int first = -1;
      int nval = 0;
      bit pending;
      @(posedge clk); #1;
      for (int c = 0; c < 16; c++) begin
         clken = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
         if (ptr < 8) drive(1, 1'b1, 1'b0, 8'(ptr), 32'd0, 4'd0);
         else drive(1, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
         @(negedge clk);
         if (c >= 3 && c <= 5) begin
            checks++;
            if (s1_waitrequest !== 1'b1 || s2_waitrequest !== 1'b1) begin
               errors++;
               $display("FAIL freeze_wait cyc %0d got %b%b exp 11", c, s1_waitrequest, s2_waitrequest);
            end
         end
         if (s1_readdatavalid) begin
            checks++;
            if (got >= 8 || c != exp_cyc[got] || s1_readdata !== pat(got)) begin
               errors++;
               $display("FAIL freeze_valid idx %0d cyc %0d data %h exp cyc %0d data %h", got, c,
                        s1_readdata, (got < 8) ? exp_cyc[got] : -1, pat(got));
            end
            got++;
         end
         if (ptr < 8 && !s1_waitrequest) ptr++;
         @(posedge clk); #1;
      end
      clken = 1'b1;
      drive(1, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
      checks++;
      if (got != 8) begin
         errors++; $display("FAIL freeze_count got %0d exp 8", got);
      end
      reset_req = 1'b1;
      pending = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (c == 2) reset_req = 1'b0;
         if (pending) drive(2, 1'b1, 1'b0, 8'd5, 32'd0, 4'd0);
         else drive(2, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
         @(negedge clk);
         if (c == 0) begin
            checks++;
            if (s1_waitrequest !== 1'b1 || s2_waitrequest !== 1'b1) begin
               errors++;
               $display("FAIL reset_req_wait got %b%b exp 11", s1_waitrequest, s2_waitrequest);
            end
         end
         if (s2_readdatavalid) begin
            nval++;
            if (first < 0) first = c;
            checks++;
            if (s2_readdata !== pat(5)) begin
               errors++; $display("FAIL reset_req_data got %h exp %h", s2_readdata, pat(5));
            end
         end
         if (pending && !s2_waitrequest) pending = 1'b0;
         @(posedge clk); #1;
      end
      checks++;
      if (first != 2 + RL || nval != 1) begin
         errors++; $display("FAIL reset_req_timing first %0d count %0d exp %0d 1", first, nval, 2 + RL);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] d, exp_new;
      int lat;
`ifdef BLINKLED_MEM_RDW_BYPASS_EN
      exp_new = 32'hAA22CC44;
`else
      exp_new = 32'hAABBCCDD;
`endif
      do_write(1, 8'd20, 32'hAABBCCDD, 4'hF);
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b1, 8'd20, 32'h11223344, 4'b0101);
      drive(2, 1'b1, 1'b0, 8'd20, 32'd0, 4'd0);
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
      drive(2, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
      wait_valid(2, d, lat);
      checks++;
      if (d !== exp_new) begin
         errors++; $display("FAIL s1w_s2r_same_cycle got %h exp %h", d, exp_new);
      end
      @(posedge clk); #1;
      drive(2, 1'b0, 1'b1, 8'd20, 32'hFFFFFFFF, 4'hF);
      drive(1, 1'b1, 1'b0, 8'd20, 32'd0, 4'd0);
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
      drive(2, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
      wait_valid(1, d, lat);
      checks++;
      if (d !== 32'hAA22CC44) begin
         errors++; $display("FAIL s2w_s1r_old got %h exp aa22cc44", d);
      end
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b1, 8'd21, 32'hAABBCCDD, 4'hF);
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b1, 8'd21, 32'h11223344, 4'b0101);
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
      drive(2, 1'b1, 1'b0, 8'd21, 32'd0, 4'd0);
      @(posedge clk); #1;
      drive(2, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
      wait_valid(2, d, lat);
      checks++;
      if (d !== 32'hAA22CC44 || lat != RL) begin
         errors++; $display("FAIL back_to_back got %h lat %0d exp aa22cc44 lat %0d", d, lat, RL);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_byte_lanes();
      test_collision();
      test_streaming();
      test_out_of_range();
      test_freeze();
      test_bypass();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
